// File: rtl/vend_controller.sv
// -----------------------------------------------------------------------------
// vend_controller
//
// Transaction sequencer of the vending datapath. It accumulates inserted coin
// value, latches the selected item price, pulses `dispense_o` for one cycle
// once the credit covers the price, then pays the remainder back as unit
// change pulses spaced CHANGE_GAP cycles apart. `balance_o` and `price_o` feed
// the 2:1 display multiplexer directly. `display_sel_o` drives that mux's
// selector: 0 shows the balance (srca), 1 shows the price (srcb).
//
// Handshake: every input strobe (coin_valid_i, sel_valid_i, cancel_i) is a
// one-cycle qualifier sampled on the rising edge. It has no ready/backpressure.
// A coin that cannot be taken is reported one cycle later on coin_reject_o.
// Selects and cancels that arrive while the machine is busy are dropped
// silently.
//
// Parameters
//   WIDTH        width of all money values, in units of the smallest coin
//   MAX_BALANCE  highest credit accepted; coins that would exceed it bounce
//   CHANGE_GAP   cycles between successive change pulses (>= 1)
//
// Ports
//   clk_i           single clock, all logic on the rising edge
//   rst_i           synchronous, active-high reset
//   coin_valid_i    coin inserted strobe (already debounced)
//   coin_value_i    value of the inserted coin, qualified by coin_valid_i
//   sel_valid_i     item selected strobe
//   sel_price_i     price of the selected item, qualified by sel_valid_i
//   cancel_i        return-whole-balance strobe
//   balance_o       current credit (registered)
//   price_o         latched item price, 0 = none (registered)
//   display_sel_o   display mux selector (registered)
//   dispense_o      one-cycle item release pulse
//   change_pulse_o  one pulse per unit of change returned
//   coin_reject_o   one-cycle pulse, previous coin returned unaccepted
//   busy_o          high while dispensing or paying out change
//   state_o         debug view of the FSM state (0 IDLE, 1 COLLECT,
//                   2 DISPENSE, 3 CHANGE)
// -----------------------------------------------------------------------------
module vend_controller #(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] MAX_BALANCE = WIDTH'(200),
    parameter int               CHANGE_GAP  = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             coin_valid_i,
    input  logic [WIDTH-1:0] coin_value_i,
    input  logic             sel_valid_i,
    input  logic [WIDTH-1:0] sel_price_i,
    input  logic             cancel_i,
    output logic [WIDTH-1:0] balance_o,
    output logic [WIDTH-1:0] price_o,
    output logic             display_sel_o,
    output logic             dispense_o,
    output logic             change_pulse_o,
    output logic             coin_reject_o,
    output logic             busy_o,
    output logic [1:0]       state_o
);

    // A gap of 1 still needs a one-bit counter that simply stays at zero.
    localparam int GAP_W = (CHANGE_GAP > 1) ? $clog2(CHANGE_GAP) : 1;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_COLLECT  = 2'd1,
        S_DISPENSE = 2'd2,
        S_CHANGE   = 2'd3
    } state_e;

    // -------------------------------------------------------------------------
    // State and registered outputs
    // -------------------------------------------------------------------------
    state_e             state_q,       state_d;
    logic [WIDTH-1:0]   balance_q,     balance_d;
    logic [WIDTH-1:0]   price_q,       price_d;
    logic [GAP_W-1:0]   gap_q,         gap_d;
    logic               display_sel_q, display_sel_d;
    logic               coin_reject_q, coin_reject_d;

    // -------------------------------------------------------------------------
    // Helper terms
    // -------------------------------------------------------------------------
    logic [WIDTH:0]     coin_sum;   // one extra bit so the limit test cannot wrap
    logic               coin_fits;
    logic               sel_ok;
    logic               covered;
    logic [WIDTH-1:0]   remainder;
    logic               gap_last;
    logic               pulse_now;

    always_comb begin
        coin_sum  = {1'b0, balance_q} + {1'b0, coin_value_i};
        coin_fits = (coin_sum <= {1'b0, MAX_BALANCE});
        sel_ok    = sel_valid_i && (sel_price_i != '0);
        // Purchase test looks only at registered balance/price, so a coin or
        // select landing this cycle cannot trigger a dispense until next cycle.
        covered   = (price_q != '0) && (balance_q >= price_q);
        remainder = balance_q - price_q;
        gap_last  = (gap_q == GAP_W'(CHANGE_GAP - 1));
        pulse_now = (state_q == S_CHANGE) && (gap_q == '0);
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d       = state_q;
        balance_d     = balance_q;
        price_d       = price_q;
        gap_d         = '0;         // held at zero outside CHANGE, so entry starts a pulse
        coin_reject_d = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                // Cancel is meaningless here: there is no credit to return.
                if (coin_valid_i && (coin_value_i != '0)) begin
                    if (coin_fits) begin
                        balance_d = coin_sum[WIDTH-1:0];
                        state_d   = S_COLLECT;
                    end else begin
                        coin_reject_d = 1'b1;
                    end
                end
                if (sel_ok) begin
                    price_d = sel_price_i;
                    state_d = S_COLLECT;
                end
            end

            S_COLLECT: begin
                if (cancel_i) begin
                    // Cancel wins over everything else arriving with it.
                    price_d       = '0;
                    coin_reject_d = coin_valid_i;
                    state_d       = (balance_q != '0) ? S_CHANGE : S_IDLE;
                end else begin
                    if (coin_valid_i) begin
                        if (coin_fits) begin
                            balance_d = coin_sum[WIDTH-1:0];
                        end else begin
                            coin_reject_d = 1'b1;
                        end
                    end
                    if (covered) begin
                        // The price is frozen for the purchase now under way,
                        // so the DISPENSE subtraction can never underflow.
                        state_d = S_DISPENSE;
                    end else if (sel_ok) begin
                        price_d = sel_price_i;
                    end
                end
            end

            S_DISPENSE: begin
                coin_reject_d = coin_valid_i;
                balance_d     = remainder;
                price_d       = '0;
                state_d       = (remainder != '0) ? S_CHANGE : S_IDLE;
            end

            S_CHANGE: begin
                coin_reject_d = coin_valid_i;
                gap_d         = gap_last ? '0 : gap_q + GAP_W'(1);
                if (pulse_now) begin
                    balance_d = balance_q - WIDTH'(1);
                    if (balance_q == WIDTH'(1)) begin
                        state_d = S_IDLE;
                        gap_d   = '0;
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        display_sel_d = (state_d == S_COLLECT) && (price_d != '0);
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= S_IDLE;
            balance_q     <= '0;
            price_q       <= '0;
            gap_q         <= '0;
            display_sel_q <= 1'b0;
            coin_reject_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            balance_q     <= balance_d;
            price_q       <= price_d;
            gap_q         <= gap_d;
            display_sel_q <= display_sel_d;
            coin_reject_q <= coin_reject_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs: pulses are pure decodes of registered state and counter
    // -------------------------------------------------------------------------
    assign balance_o      = balance_q;
    assign price_o        = price_q;
    assign display_sel_o  = display_sel_q;
    assign coin_reject_o  = coin_reject_q;
    assign dispense_o     = (state_q == S_DISPENSE);
    assign change_pulse_o = pulse_now;
    assign busy_o         = (state_q == S_DISPENSE) || (state_q == S_CHANGE);
    assign state_o        = state_q;

    // -------------------------------------------------------------------------
    // Invariants
    // -------------------------------------------------------------------------
    a_no_overlap : assert property (@(posedge clk_i) disable iff (rst_i)
        !(dispense_o && change_pulse_o));

    a_balance_cap : assert property (@(posedge clk_i) disable iff (rst_i)
        balance_q <= MAX_BALANCE);

endmodule

// File: tb/tb_vend_controller.sv
// -----------------------------------------------------------------------------
// tb_vend_controller
//
// Directed bench for vend_controller. A transaction-level model keeps credit,
// price and, once a purchase or cancel commits, a precomputed per-cycle payout
// timeline. Every cycle the DUT outputs are compared against that model, and
// hand-computed literals pin the key points of each scenario.
// -----------------------------------------------------------------------------
module tb_vend_controller;

  localparam int W    = 8;
  localparam int MAXB = 200;
  localparam int GAP  = 4;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst        = 1'b1;
  logic         coin_valid = 1'b0;
  logic [W-1:0] coin_value = '0;
  logic         sel_valid  = 1'b0;
  logic [W-1:0] sel_price  = '0;
  logic         cancel     = 1'b0;

  logic [W-1:0] balance;
  logic [W-1:0] price;
  logic         display_sel;
  logic         dispense;
  logic         change_pulse;
  logic         coin_reject;
  logic         busy;
  logic [1:0]   state;

  vend_controller #(
    .WIDTH       (W),
    .MAX_BALANCE (W'(MAXB)),
    .CHANGE_GAP  (GAP)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .coin_valid_i   (coin_valid),
    .coin_value_i   (coin_value),
    .sel_valid_i    (sel_valid),
    .sel_price_i    (sel_price),
    .cancel_i       (cancel),
    .balance_o      (balance),
    .price_o        (price),
    .display_sel_o  (display_sel),
    .dispense_o     (dispense),
    .change_pulse_o (change_pulse),
    .coin_reject_o  (coin_reject),
    .busy_o         (busy),
    .state_o        (state)
  );

  // ---------------------------------------------------------------------------
  // Behavioural model
  //   m_bal / m_price : credit and selected price while not paying out
  //   plan_q          : expected outputs, one entry per cycle, of a payout
  //                     (optional dispense cycle followed by the change train)
  // ---------------------------------------------------------------------------
  typedef struct packed {
    logic [W-1:0] bal;
    logic [W-1:0] price;
    logic         disp;
    logic         pulse;
  } plan_t;

  plan_t plan_q[$];
  int    m_bal   = 0;
  int    m_price = 0;
  logic  m_rej   = 1'b0;

  function automatic plan_t mk(input int b, input int p, input logic d, input logic c);
    plan_t e;
    e.bal   = W'(b);
    e.price = W'(p);
    e.disp  = d;
    e.pulse = c;
    return e;
  endfunction

  // R unit pulses, GAP cycles apart; the last pulse is followed directly by idle.
  task automatic add_change(input int r);
    for (int i = 0; i < r; i++) begin
      plan_q.push_back(mk(r - i, 0, 1'b0, 1'b1));
      if (i < r - 1) begin
        for (int g = 1; g < GAP; g++) plan_q.push_back(mk(r - i - 1, 0, 1'b0, 1'b0));
      end
    end
  endtask

  always @(posedge clk) begin
    if (rst) begin
      plan_q.delete();
      m_bal   = 0;
      m_price = 0;
      m_rej   = 1'b0;
    end else if (plan_q.size() != 0) begin
      // Paying out: every coin bounces, selects and cancels are dropped.
      m_rej = coin_valid;
      void'(plan_q.pop_front());
      if (plan_q.size() == 0) begin
        m_bal   = 0;
        m_price = 0;
      end
    end else if (m_bal != 0 || m_price != 0) begin
      // Holding credit or a selection.
      m_rej = 1'b0;
      if (cancel) begin
        m_rej   = coin_valid;
        m_price = 0;
        if (m_bal != 0) add_change(m_bal);
      end else begin
        bit paid;
        paid = (m_price != 0) && (m_bal >= m_price);
        if (coin_valid) begin
          if (m_bal + int'(coin_value) > MAXB) m_rej = 1'b1;
          else m_bal = m_bal + int'(coin_value);
        end
        if (paid) begin
          plan_q.push_back(mk(m_bal, m_price, 1'b1, 1'b0));
          add_change(m_bal - m_price);
        end else if (sel_valid && sel_price != 0) begin
          m_price = int'(sel_price);
        end
      end
    end else begin
      // Empty machine.
      m_rej = 1'b0;
      if (coin_valid && coin_value != 0) begin
        if (int'(coin_value) > MAXB) m_rej = 1'b1;
        else m_bal = int'(coin_value);
      end
      if (sel_valid && sel_price != 0) m_price = int'(sel_price);
    end
  end

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  int n_tests = 0;
  int n_fail  = 0;
  int n_disp  = 0;
  int n_pulse = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_model();
    logic [W-1:0] e_bal, e_price;
    logic         e_disp, e_pulse, e_busy, e_dsel;
    logic [1:0]   e_state;
    if (plan_q.size() != 0) begin
      e_bal   = plan_q[0].bal;
      e_price = plan_q[0].price;
      e_disp  = plan_q[0].disp;
      e_pulse = plan_q[0].pulse;
      e_busy  = 1'b1;
      e_dsel  = 1'b0;
      e_state = plan_q[0].disp ? 2'd2 : 2'd3;
    end else begin
      e_bal   = W'(m_bal);
      e_price = W'(m_price);
      e_disp  = 1'b0;
      e_pulse = 1'b0;
      e_busy  = 1'b0;
      e_dsel  = (m_price != 0);
      e_state = (m_bal != 0 || m_price != 0) ? 2'd1 : 2'd0;
    end
    check("model_balance",     32'(balance),      32'(e_bal));
    check("model_price",       32'(price),        32'(e_price));
    check("model_display_sel", 32'(display_sel),  32'(e_dsel));
    check("model_dispense",    32'(dispense),     32'(e_disp));
    check("model_change",      32'(change_pulse), 32'(e_pulse));
    check("model_reject",      32'(coin_reject),  32'(m_rej));
    check("model_busy",        32'(busy),         32'(e_busy));
    check("model_state",       32'(state),        32'(e_state));
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks (inputs change just after a falling edge)
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(negedge clk);
    compare_model();
    if (dispense === 1'b1)     n_disp++;
    if (change_pulse === 1'b1) n_pulse++;
  endtask

  task automatic apply(input logic cv, input logic [W-1:0] cval,
                       input logic sv, input logic [W-1:0] sp, input logic cn);
    coin_valid = cv;
    coin_value = cval;
    sel_valid  = sv;
    sel_price  = sp;
    cancel     = cn;
    tick();
    coin_valid = 1'b0;
    coin_value = '0;
    sel_valid  = 1'b0;
    sel_price  = '0;
    cancel     = 1'b0;
  endtask

  task automatic coin(input logic [W-1:0] v);
    apply(1'b1, v, 1'b0, '0, 1'b0);
  endtask

  task automatic sel(input logic [W-1:0] p);
    apply(1'b0, '0, 1'b1, p, 1'b0);
  endtask

  task automatic wait_idle(output int cycles);
    cycles = 0;
    while (state != 2'd0 && cycles < 2000) begin
      tick();
      cycles++;
    end
    check("wait_idle_timeout", 32'(state), 32'd0);
  endtask

  // ---------------------------------------------------------------------------
  // Directed scenarios
  // ---------------------------------------------------------------------------
  initial begin
    int d0, p0, cyc;

    repeat (2) tick();
    check("reset_balance", 32'(balance), 32'd0);
    check("reset_state",   32'(state),   32'd0);
    check("reset_busy",    32'(busy),    32'd0);
    rst = 1'b0;
    tick();

    // Exact purchase: 5 + 5 then select 10.
    d0 = n_disp; p0 = n_pulse;
    coin(8'd5);
    tick();
    coin(8'd5);
    check("s1_balance_10", 32'(balance), 32'd10);
    sel(8'd10);
    check("s1_price_10",   32'(price),       32'd10);
    check("s1_dsel",       32'(display_sel), 32'd1);
    tick();
    check("s1_dispense",   32'(dispense),    32'd1);
    tick();
    check("s1_idle",       32'(state),       32'd0);
    check("s1_balance_0",  32'(balance),     32'd0);
    check("s1_disp_count", 32'(n_disp - d0),  32'd1);
    check("s1_pulse_count",32'(n_pulse - p0), 32'd0);

    // Select 7, pay 10: one dispense, then 3 pulses GAP apart.
    d0 = n_disp; p0 = n_pulse;
    sel(8'd7);
    coin(8'd10);
    check("s2_balance_10", 32'(balance), 32'd10);
    tick();
    check("s2_dispense",   32'(dispense), 32'd1);
    wait_idle(cyc);
    check("s2_payout_cycles", 32'(cyc), 32'd10);
    check("s2_disp_count",  32'(n_disp - d0),  32'd1);
    check("s2_pulse_count", 32'(n_pulse - p0), 32'd3);
    check("s2_balance_0",   32'(balance), 32'd0);

    // Limits: oversize coin when empty, then 195 + 10 bounces, 195 + 5 fits.
    coin(8'd201);
    check("s3_reject_idle", 32'(coin_reject), 32'd1);
    check("s3_idle_bal",    32'(balance),     32'd0);
    coin(8'd100);
    coin(8'd95);
    check("s3_balance_195", 32'(balance), 32'd195);
    coin(8'd10);
    check("s3_reject",      32'(coin_reject), 32'd1);
    check("s3_keep_195",    32'(balance),     32'd195);
    coin(8'd5);
    check("s3_balance_200", 32'(balance),     32'd200);
    check("s3_no_reject",   32'(coin_reject), 32'd0);
    sel(8'd200);
    wait_idle(cyc);
    check("s3_balance_0",   32'(balance), 32'd0);

    // Cancel ignored when empty (coin accepted), then cancel + coin in COLLECT.
    d0 = n_disp; p0 = n_pulse;
    apply(1'b1, 8'd12, 1'b0, '0, 1'b1);
    check("s4_idle_cancel_ignored", 32'(balance), 32'd12);
    apply(1'b1, 8'd5, 1'b0, '0, 1'b1);
    check("s4_reject",     32'(coin_reject),  32'd1);
    check("s4_price_0",    32'(price),        32'd0);
    check("s4_first_pulse",32'(change_pulse), 32'd1);
    wait_idle(cyc);
    check("s4_pulse_count",32'(n_pulse - p0), 32'd12);
    check("s4_no_dispense",32'(n_disp - d0),  32'd0);
    check("s4_balance_0",  32'(balance),      32'd0);

    // Coin and select while paying out change.
    p0 = n_pulse;
    coin(8'd3);
    apply(1'b0, '0, 1'b0, '0, 1'b1);
    coin(8'd20);
    check("s5_reject_in_change", 32'(coin_reject), 32'd1);
    check("s5_still_busy",       32'(busy),        32'd1);
    sel(8'd9);
    check("s5_price_stays_0",    32'(price),       32'd0);
    wait_idle(cyc);
    check("s5_pulse_count",      32'(n_pulse - p0), 32'd3);

    // Reselect overwrites, zero-price select ignored, purchase with change.
    p0 = n_pulse;
    sel(8'd50);
    sel(8'd30);
    check("s7_price_30", 32'(price), 32'd30);
    apply(1'b1, 8'd25, 1'b1, 8'd0, 1'b0);
    check("s7_zero_sel_ignored", 32'(price), 32'd30);
    check("s7_balance_25",       32'(balance), 32'd25);
    coin(8'd10);
    tick();
    check("s7_dispense",   32'(dispense), 32'd1);
    check("s7_disp_bal",   32'(balance),  32'd35);
    wait_idle(cyc);
    check("s7_pulse_count",32'(n_pulse - p0), 32'd5);

    // Reset in the middle of a 5-pulse payout.
    p0 = n_pulse;
    coin(8'd5);
    apply(1'b0, '0, 1'b0, '0, 1'b1);
    cyc = 0;
    while ((n_pulse - p0) < 2 && cyc < 40) begin
      tick();
      cyc++;
    end
    check("s6_two_pulses", 32'(n_pulse - p0), 32'd2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("s6_rst_balance", 32'(balance),      32'd0);
    check("s6_rst_price",   32'(price),        32'd0);
    check("s6_rst_state",   32'(state),        32'd0);
    check("s6_rst_pulse",   32'(change_pulse), 32'd0);
    check("s6_rst_busy",    32'(busy),         32'd0);
    check("s6_rst_reject",  32'(coin_reject),  32'd0);
    check("s6_rst_dsel",    32'(display_sel),  32'd0);
    repeat (20) tick();
    check("s6_no_more_pulses", 32'(n_pulse - p0), 32'd2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/vend_controller.md
# vend_controller

Core transaction sequencer of the vending datapath. It accumulates inserted coin value, latches the selected item price, and issues a one-cycle dispense pulse once the balance covers the price. It then pays out the remainder as unit change pulses. Its `balance` and `price` outputs feed the 2:1 display multiplexer directly, and `display_sel` drives that multiplexer's selector (0 = balance on srca, 1 = price on srcb).

## Interface
- `WIDTH`, 8: width of all money values (units of smallest coin).
- `MAX_BALANCE`, 8'd200: highest balance accepted; coins that would exceed it are rejected.
- `CHANGE_GAP`, 4: cycles between successive change pulses (≥1).
- `clk` input 1: single clock; all logic on rising edge.
- `rst` input 1: synchronous, active-high reset.
- `coin_valid` input 1: one-cycle strobe, coin inserted (already debounced).
- `coin_value` input WIDTH: value of the inserted coin; qualified by `coin_valid`.
- `sel_valid` input 1: one-cycle strobe, item selected.
- `sel_price` input WIDTH: price of the selected item; qualified by `sel_valid`.
- `cancel` input 1: one-cycle strobe, return the whole balance.
- `balance` output WIDTH: current credit, registered.
- `price` output WIDTH: latched item price, registered; 0 = none selected.
- `display_sel` output 1: mux selector, registered; 1 when `price` ≠ 0 in COLLECT, else 0.
- `dispense` output 1: one-cycle item-release pulse.
- `change_pulse` output 1: one pulse per unit of change returned.
- `coin_reject` output 1: one-cycle pulse, last coin returned unaccepted.
- `busy` output 1: high in DISPENSE or CHANGE.

## Operation
- States: IDLE, COLLECT, DISPENSE, CHANGE. State is registered.
- Reset: state IDLE. All outputs 0. Gap counter 0. Pending change is discarded.
- IDLE:
  - A valid coin (value ≠ 0, within limit) adds to `balance` and moves to COLLECT.
  - `sel_valid` with `sel_price` ≠ 0 latches `price` and moves to COLLECT.
  - `cancel` is ignored.
- COLLECT, priority `cancel` > coin/select:
  - `cancel`: `price` ← 0. Go CHANGE if `balance` ≠ 0, else IDLE. A coin in the same cycle is rejected.
  - Coin: if `balance + coin_value` > `MAX_BALANCE` (computed WIDTH+1 bits), reject. Otherwise add.
  - Select: `sel_price` ≠ 0 overwrites `price`; `sel_price` = 0 is ignored. Coin and select in the same cycle are both applied.
  - If registered `price` ≠ 0 and `balance` ≥ `price`, go DISPENSE. This test uses current registered values only.
- DISPENSE, exactly one cycle:
  - `dispense` = 1.
  - At the end of the cycle, `balance` ← `balance − price` and `price` ← 0.
  - Next state is CHANGE if the remainder ≠ 0, else IDLE.
- CHANGE:
  - Gap counter is cleared on entry and counts 0..`CHANGE_GAP`−1, wrapping.
  - `change_pulse` = (state == CHANGE && gap == 0).
  - Each pulse decrements `balance` by 1 at the end of that cycle.
  - On the pulse where `balance` == 1, go IDLE.
- Coins arriving in DISPENSE or CHANGE are rejected. `sel_valid` and `cancel` are ignored in those states.
- `coin_reject` is registered: high in the cycle after the rejected coin strobe.

## Timing
- Coin accepted at cycle n → `balance` updated at n+1. If this covers `price`, state is DISPENSE and `dispense` = 1 during n+2.
- Remaining change R → R pulses, spaced `CHANGE_GAP` cycles apart. The first pulse is in the first CHANGE cycle. IDLE is entered the cycle after the last pulse, with `balance` = 0.
- `dispense` and `change_pulse` are decoded from registered state and counter. Neither is ever high in the same cycle as the other.
- `balance` never exceeds `MAX_BALANCE` and never underflows.
- Reset asserted in any state takes priority over all inputs at that edge.

## Test plan
- Reset, then coins 5, 5 at cycles 1 and 3; sel 10 at cycle 4 → `balance` = 10 at 4, `price` = 10 at 5, `dispense` at 6, `change_pulse` never, IDLE at 7, `balance` = 0.
- Sel 7, then coin 10 (`CHANGE_GAP` = 4) → one `dispense`, then 3 `change_pulse`s 4 cycles apart, final `balance` = 0.
- `balance` = 195, coin 10 → `coin_reject` next cycle, `balance` stays 195. Then coin 5 → `balance` = 200.
- COLLECT with `balance` = 12: `cancel` and coin 5 in the same cycle → coin rejected, 12 change pulses, no `dispense`, `price` = 0.
- Coin 20 during CHANGE → `coin_reject`, pulse count unchanged. `sel_valid` during CHANGE → `price` stays 0.
- `rst` after the 2nd of 5 change pulses → next cycle all outputs 0, state IDLE, no further pulses.
